// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter sequencer: FSM states, command
// opcodes and the configuration reset value.
package counter_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_PAUSE,
    ST_FLUSH
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_START = 2'd1;
  localparam logic [1:0] OP_STOP  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  // Replicated to the counter width, so the reset limit is all ones.
  localparam logic LIMIT_RST_BIT = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Prescale counter: issues a tick every pre+1 running cycles, holds its count
// while paused and restarts from zero otherwise.
module tick_prescaler #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             hold,
  input  logic             zero,
  input  logic [PRE_W-1:0] pre,
  output logic             tick
);

  logic [PRE_W-1:0] r_pc;

  assign tick = run && (r_pc == pre);

  // NOTE: state updates use non-blocking assignments so every register samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= '0;
    end else if (zero) begin
      r_pc <= '0;
    end else if (run) begin
      r_pc <= tick ? '0 : r_pc + 1'b1;
    end else if (!hold) begin
      r_pc <= '0;
    end
  end

endmodule

// File: rtl/counter_seq.sv
// Command-driven sequencer turning an external free-running counter into a
// one-shot or periodic timer via its increment and clear strobes.
module counter_seq
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic [PRE_W-1:0] cmd_pre,
  input  logic             cmd_periodic,
  input  logic [WIDTH-1:0] cnt_val,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic             done,
  output logic             busy,
  output logic             err
);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_limit;
  logic [PRE_W-1:0] r_pre;
  logic             r_periodic;
  logic             r_err;

  logic w_accept;
  logic w_run;
  logic w_hold;
  logic w_zero;
  logic w_tick;
  logic w_terminal;
  logic w_load_ok;
  logic w_load_bad;

  assign w_run  = (r_state == ST_RUN);
  assign w_hold = (r_state == ST_PAUSE);
  assign w_zero = (r_state == ST_IDLE) || (r_state == ST_ARM) || (r_state == ST_FLUSH);

  assign cmd_ready  = (r_state != ST_ARM) && (r_state != ST_FLUSH);
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_load_ok  = w_accept && (cmd_op == OP_LOAD) && (r_state == ST_IDLE);
  assign w_load_bad = w_accept && (cmd_op == OP_LOAD) && (w_run || w_hold);

  tick_prescaler #(
    .PRE_W(PRE_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .run  (w_run),
    .hold (w_hold),
    .zero (w_zero),
    .pre  (r_pre),
    .tick (w_tick)
  );

  // Strobes depend only on registered state and the counter, never on cmd_*.
  assign w_terminal = w_tick && (cnt_val == r_limit);
  assign cnt_en     = w_tick && !w_terminal;
  assign done       = w_terminal;
  assign cnt_clr    = w_terminal || (r_state == ST_ARM) || (r_state == ST_FLUSH);
  assign busy       = (r_state == ST_ARM) || w_run || w_hold;
  assign err        = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_limit    <= {WIDTH{LIMIT_RST_BIT}};
      r_pre      <= '0;
      r_periodic <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_load_bad;
      if (w_load_ok) begin
        r_limit    <= cmd_limit;
        r_pre      <= cmd_pre;
        r_periodic <= cmd_periodic;
      end
    end
  end

  // NOTE: w_next takes its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (cmd_op == OP_START)) w_next = ST_ARM;
        else if (w_accept && (cmd_op == OP_CLEAR)) w_next = ST_FLUSH;
      end
      ST_ARM:   w_next = ST_RUN;
      ST_RUN: begin
        // CLEAR beats a one-shot terminal count, which beats STOP.
        if (w_accept && (cmd_op == OP_CLEAR)) w_next = ST_FLUSH;
        else if (w_terminal && !r_periodic) w_next = ST_IDLE;
        else if (w_accept && (cmd_op == OP_STOP)) w_next = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (w_accept && (cmd_op == OP_CLEAR)) w_next = ST_FLUSH;
        else if (w_accept && (cmd_op == OP_START)) w_next = ST_RUN;
      end
      ST_FLUSH: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_counter_seq.sv
// Directed bench for counter_seq with a behavioural model of the external
// 8-bit counter; each task checks one scenario cycle by cycle.
module tb_counter_seq;

  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] STOP  = 2'd2;
  localparam logic [1:0] CLEAR = 2'd3;

  // {busy, cmd_ready, cnt_en, cnt_clr, done}
  localparam logic [4:0] O_IDLE  = 5'b01000;
  localparam logic [4:0] O_ARM   = 5'b10010;
  localparam logic [4:0] O_RUN   = 5'b11000;
  localparam logic [4:0] O_EN    = 5'b11100;
  localparam logic [4:0] O_DONE  = 5'b11011;
  localparam logic [4:0] O_FLUSH = 5'b00010;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_limit = 8'd0;
  logic [3:0] cmd_pre = 4'd0;
  logic       cmd_periodic = 1'b0;
  logic [7:0] cnt_val;
  logic       cnt_en, cnt_clr, done, busy, err;
  logic [4:0] w_outs;

  int n_pass = 0;
  int n_total = 0;

  assign w_outs = {busy, cmd_ready, cnt_en, cnt_clr, done};

  always #5 clk = ~clk;

  counter_seq #(.WIDTH(8), .PRE_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_limit    (cmd_limit),
    .cmd_pre      (cmd_pre),
    .cmd_periodic (cmd_periodic),
    .cnt_val      (cnt_val),
    .cnt_en       (cnt_en),
    .cnt_clr      (cnt_clr),
    .done         (done),
    .busy         (busy),
    .err          (err)
  );

  // External registered counter: clear has priority over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_val <= 8'd0;
    else if (cnt_clr) cnt_val <= 8'd0;
    else if (cnt_en) cnt_val <= cnt_val + 8'd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] lim,
                      input logic [3:0] pre, input logic per);
    cmd_valid = 1'b1; cmd_op = op; cmd_limit = lim; cmd_pre = pre; cmd_periodic = per;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    step();
    n_total++;
    if (w_outs !== O_IDLE) $display("FAIL reset_outs got=%b want=%b", w_outs, O_IDLE); else n_pass++;
    n_total++;
    if (err !== 1'b0) $display("FAIL reset_err got=%b want=0", err); else n_pass++;
  endtask

  task automatic test_one_shot();
    logic [4:0] exp;
    send(LOAD, 8'd3, 4'd1, 1'b0);
    n_total++;
    if (w_outs !== O_IDLE) $display("FAIL oneshot_load got=%b want=%b", w_outs, O_IDLE); else n_pass++;
    send(START, 8'd0, 4'd0, 1'b0);
    n_total++;
    if (w_outs !== O_ARM) $display("FAIL oneshot_arm got=%b want=%b", w_outs, O_ARM); else n_pass++;
    step();
    for (int i = 0; i < 8; i++) begin
      exp = (i == 7) ? O_DONE : ((i % 2) == 1) ? O_EN : O_RUN;
      n_total++;
      if (w_outs !== exp) $display("FAIL oneshot_run%0d got=%b want=%b", i, w_outs, exp); else n_pass++;
      step();
    end
    n_total++;
    if (w_outs !== O_IDLE) $display("FAIL oneshot_idle got=%b want=%b", w_outs, O_IDLE); else n_pass++;
  endtask

  task automatic test_periodic();
    logic [4:0] exp;
    send(LOAD, 8'd2, 4'd0, 1'b1);
    send(START, 8'd0, 4'd0, 1'b0);
    n_total++;
    if (w_outs !== O_ARM) $display("FAIL periodic_arm got=%b want=%b", w_outs, O_ARM); else n_pass++;
    step();
    for (int i = 0; i < 12; i++) begin
      exp = ((i % 3) == 2) ? O_DONE : O_EN;
      n_total++;
      if (w_outs !== exp) $display("FAIL periodic_run%0d got=%b want=%b", i, w_outs, exp); else n_pass++;
      n_total++;
      if (cnt_val !== 8'(i % 3)) $display("FAIL periodic_cnt%0d got=%0d want=%0d", i, cnt_val, i % 3); else n_pass++;
      if (i == 11) send(STOP, 8'd0, 4'd0, 1'b0);
      else step();
    end
    // STOP on a periodic done cycle lands in PAUSE with the counter wrapped.
    n_total++;
    if (w_outs !== O_RUN) $display("FAIL stop_on_done got=%b want=%b", w_outs, O_RUN); else n_pass++;
    n_total++;
    if (cnt_val !== 8'd0) $display("FAIL stop_on_done_cnt got=%0d want=0", cnt_val); else n_pass++;
    send(CLEAR, 8'd0, 4'd0, 1'b0);
    n_total++;
    if (w_outs !== O_FLUSH) $display("FAIL pause_clear_flush got=%b want=%b", w_outs, O_FLUSH); else n_pass++;
    step();
    n_total++;
    if (w_outs !== O_IDLE) $display("FAIL pause_clear_idle got=%b want=%b", w_outs, O_IDLE); else n_pass++;
  endtask

  task automatic test_pause_resume();
    send(LOAD, 8'd5, 4'd3, 1'b0);
    send(START, 8'd0, 4'd0, 1'b0);
    step();
    n_total++;
    if (w_outs !== O_RUN) $display("FAIL pr_run0 got=%b want=%b", w_outs, O_RUN); else n_pass++;
    step();
    n_total++;
    if (w_outs !== O_RUN) $display("FAIL pr_run1 got=%b want=%b", w_outs, O_RUN); else n_pass++;
    send(STOP, 8'd0, 4'd0, 1'b0);
    for (int p = 0; p < 5; p++) begin
      n_total++;
      if (w_outs !== O_RUN) $display("FAIL pr_pause%0d got=%b want=%b", p, w_outs, O_RUN); else n_pass++;
      if (p == 4) send(START, 8'd0, 4'd0, 1'b0);
      else step();
    end
    n_total++;
    if (w_outs !== O_RUN) $display("FAIL pr_resume0 got=%b want=%b", w_outs, O_RUN); else n_pass++;
    step();
    n_total++;
    if (w_outs !== O_EN) $display("FAIL pr_resume_tick got=%b want=%b", w_outs, O_EN); else n_pass++;
    // CLEAR on the tick cycle: the strobe still reaches the counter.
    send(CLEAR, 8'd0, 4'd0, 1'b0);
    n_total++;
    if (w_outs !== O_FLUSH) $display("FAIL clr_tick_flush got=%b want=%b", w_outs, O_FLUSH); else n_pass++;
    n_total++;
    if (cnt_val !== 8'd1) $display("FAIL clr_tick_cnt got=%0d want=1", cnt_val); else n_pass++;
    step();
    n_total++;
    if (w_outs !== O_IDLE) $display("FAIL clr_tick_idle got=%b want=%b", w_outs, O_IDLE); else n_pass++;
    n_total++;
    if (cnt_val !== 8'd0) $display("FAIL clr_tick_cnt0 got=%0d want=0", cnt_val); else n_pass++;
  endtask

  task automatic test_illegal_load();
    send(LOAD, 8'd2, 4'd0, 1'b0);
    send(START, 8'd0, 4'd0, 1'b0);
    cmd_valid = 1'b1; cmd_op = CLEAR;
    n_total++;
    if (w_outs !== O_ARM) $display("FAIL arm_stall got=%b want=%b", w_outs, O_ARM); else n_pass++;
    step();
    n_total++;
    if (w_outs !== O_EN) $display("FAIL arm_stall_run got=%b want=%b", w_outs, O_EN); else n_pass++;
    step();
    cmd_valid = 1'b0;
    n_total++;
    if (w_outs !== O_FLUSH) $display("FAIL arm_stall_flush got=%b want=%b", w_outs, O_FLUSH); else n_pass++;
    step();
    send(START, 8'd0, 4'd0, 1'b0);
    step();
    n_total++;
    if (w_outs !== O_EN) $display("FAIL ill_run0 got=%b want=%b", w_outs, O_EN); else n_pass++;
    send(LOAD, 8'd7, 4'd0, 1'b1);
    n_total++;
    if (err !== 1'b1) $display("FAIL ill_err_pulse got=%b want=1", err); else n_pass++;
    n_total++;
    if (w_outs !== O_EN) $display("FAIL ill_run1 got=%b want=%b", w_outs, O_EN); else n_pass++;
    step();
    n_total++;
    if (err !== 1'b0) $display("FAIL ill_err_clear got=%b want=0", err); else n_pass++;
    n_total++;
    if (w_outs !== O_DONE) $display("FAIL ill_limit_kept got=%b want=%b", w_outs, O_DONE); else n_pass++;
    // START on a one-shot done cycle is dropped: state returns to IDLE.
    send(START, 8'd0, 4'd0, 1'b0);
    n_total++;
    if (w_outs !== O_IDLE) $display("FAIL start_on_done got=%b want=%b", w_outs, O_IDLE); else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [4:0] exp;
    send(LOAD, 8'd9, 4'd0, 1'b1);
    send(START, 8'd0, 4'd0, 1'b0);
    step();
    send(LOAD, 8'd1, 4'd1, 1'b0);
    n_total++;
    if ({err, w_outs} !== {1'b1, O_EN}) $display("FAIL ar_before got=%b want=%b", {err, w_outs}, {1'b1, O_EN}); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({cnt_en, cnt_clr, done, busy, err, cmd_ready} !== 6'b000001)
      $display("FAIL ar_immediate got=%b want=000001", {cnt_en, cnt_clr, done, busy, err, cmd_ready});
    else n_pass++;
    #3 rst = 1'b0;
    step();
    n_total++;
    if ({err, w_outs} !== {1'b0, O_IDLE}) $display("FAIL ar_release got=%b want=%b", {err, w_outs}, {1'b0, O_IDLE}); else n_pass++;
    send(START, 8'd0, 4'd0, 1'b0);
    n_total++;
    if (w_outs !== O_ARM) $display("FAIL ar_arm got=%b want=%b", w_outs, O_ARM); else n_pass++;
    step();
    for (int i = 0; i < 256; i++) begin
      exp = (i == 255) ? O_DONE : O_EN;
      n_total++;
      if (w_outs !== exp) $display("FAIL ar_default_run%0d got=%b want=%b", i, w_outs, exp); else n_pass++;
      step();
    end
    n_total++;
    if (w_outs !== O_IDLE) $display("FAIL ar_default_idle got=%b want=%b", w_outs, O_IDLE); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_pause_resume();
    test_illegal_load();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
